// File: rtl/cpu_run_monitor_if.sv
// CPU run-monitor bus: sampled CPU state in, run status and trace read out.
// CPU_MON_PC_RANGE_EN adds the pc_lo/pc_hi window bounds.
interface cpu_run_monitor_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_WIDTH   = 16
);
  localparam int IW = $clog2(TRACE_DEPTH);

  logic                   start;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   running;
  logic                   done;
  logic [2:0]             halt_reason;
  logic [CNT_WIDTH-1:0]   cycle_count;
  logic [ADDR_WIDTH-1:0]  halt_pc;
  logic [IW-1:0]          trace_rd_idx;
  logic [ADDR_WIDTH-1:0]  trace_rd_pc;
  logic [INSTR_WIDTH-1:0] trace_rd_instr;
  logic [IW:0]            trace_count;
`ifdef CPU_MON_PC_RANGE_EN
  logic [ADDR_WIDTH-1:0]  pc_lo;
  logic [ADDR_WIDTH-1:0]  pc_hi;
`endif

  modport master (
`ifdef CPU_MON_PC_RANGE_EN
    output pc_lo,
    output pc_hi,
`endif
    output start,
    output pc,
    output instruction,
    output trace_rd_idx,
    input  running,
    input  done,
    input  halt_reason,
    input  cycle_count,
    input  halt_pc,
    input  trace_rd_pc,
    input  trace_rd_instr,
    input  trace_count
  );

  modport slave (
`ifdef CPU_MON_PC_RANGE_EN
    input  pc_lo,
    input  pc_hi,
`endif
    input  start,
    input  pc,
    input  instruction,
    input  trace_rd_idx,
    output running,
    output done,
    output halt_reason,
    output cycle_count,
    output halt_pc,
    output trace_rd_pc,
    output trace_rd_instr,
    output trace_count
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run-control and trace monitor: syscall / self-loop / timeout halts + trace ring.
// CPU_MON_PC_RANGE_EN enables the out-of-range PC halt (reason 4).
module cpu_run_monitor #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int TRACE_DEPTH    = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int LOOP_LIMIT     = 3
) (
  input logic               clk,
  input logic               reset_n,
  cpu_run_monitor_if.slave  mon
);
  localparam int IW = $clog2(TRACE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [2:0] R_NONE  = 3'd0;
  localparam logic [2:0] R_SYS   = 3'd1;
  localparam logic [2:0] R_LOOP  = 3'd2;
  localparam logic [2:0] R_TMO   = 3'd3;
`ifdef CPU_MON_PC_RANGE_EN
  localparam logic [2:0] R_RANGE = 3'd4;
`endif

  localparam logic [IW:0]          TC_MAX = (IW+1)'(TRACE_DEPTH);
  localparam logic [CNT_WIDTH-1:0] L_LIM  = CNT_WIDTH'(LOOP_LIMIT);
  localparam logic [CNT_WIDTH-1:0] T_LIM  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]   loop_q, loop_d;
  logic [IW:0]            tcnt_q, tcnt_d;
  logic [IW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  prev_pc_q, prev_pc_d;
  logic [ADDR_WIDTH-1:0]  halt_pc_q, halt_pc_d;
  logic [2:0]             reason_q, reason_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;

  logic                   wr_en;
  logic [CNT_WIDTH-1:0]   cycle_nx;
  logic [CNT_WIDTH-1:0]   loop_nx;
  logic                   is_sys;
  logic                   is_loop;
  logic                   is_tmo;
  logic                   out_rng;
  logic [IW-1:0]          rd_phys;

  logic [ADDR_WIDTH-1:0]  tr_pc_q  [TRACE_DEPTH];
  logic [INSTR_WIDTH-1:0] tr_ins_q [TRACE_DEPTH];

  // Halt conditions, evaluated against this cycle's sample
  assign cycle_nx = cycle_q + ONE;
  assign loop_nx  = (cycle_q != '0 && mon.pc == prev_pc_q)
                  ? loop_q + ONE : ONE;
  assign is_sys   = (mon.instruction[31:26] == 6'h00)
                 && (mon.instruction[5:0] == 6'h0C);
  assign is_loop  = (loop_nx == L_LIM);
  assign is_tmo   = (cycle_nx == T_LIM);
`ifdef CPU_MON_PC_RANGE_EN
  assign out_rng  = (mon.pc < mon.pc_lo) || (mon.pc > mon.pc_hi);
`else
  assign out_rng  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    loop_d    = loop_q;
    tcnt_d    = tcnt_q;
    wr_ptr_d  = wr_ptr_q;
    prev_pc_d = prev_pc_q;
    halt_pc_d = halt_pc_q;
    reason_d  = reason_q;
    wr_en     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (mon.start) begin
          state_d   = S_RUN;
          cycle_d   = '0;
          loop_d    = '0;
          tcnt_d    = '0;
          wr_ptr_d  = '0;
          halt_pc_d = '0;
          reason_d  = R_NONE;
        end
      end
      S_RUN: begin
        wr_en     = 1'b1;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        tcnt_d    = (tcnt_q == TC_MAX) ? tcnt_q : tcnt_q + 1'b1;
        cycle_d   = cycle_nx;
        loop_d    = loop_nx;
        prev_pc_d = mon.pc;
        if (is_sys || out_rng || is_loop || is_tmo) begin
          state_d   = S_DONE;
          halt_pc_d = mon.pc;
          if (is_sys)        reason_d = R_SYS;
`ifdef CPU_MON_PC_RANGE_EN
          else if (out_rng)  reason_d = R_RANGE;
`endif
          else if (is_loop)  reason_d = R_LOOP;
          else               reason_d = R_TMO;
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cycle_q   <= '0;
      loop_q    <= '0;
      tcnt_q    <= '0;
      wr_ptr_q  <= '0;
      prev_pc_q <= '0;
      halt_pc_q <= '0;
      reason_q  <= R_NONE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      loop_q    <= loop_d;
      tcnt_q    <= tcnt_d;
      wr_ptr_q  <= wr_ptr_d;
      prev_pc_q <= prev_pc_d;
      halt_pc_q <= halt_pc_d;
      reason_q  <= reason_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // Trace storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      tr_pc_q[wr_ptr_q]  <= mon.pc;
      tr_ins_q[wr_ptr_q] <= mon.instruction;
    end
  end

  assign rd_phys = wr_ptr_q - tcnt_q[IW-1:0] + mon.trace_rd_idx;

  assign mon.trace_rd_pc    = tr_pc_q[rd_phys];
  assign mon.trace_rd_instr = tr_ins_q[rd_phys];
  assign mon.trace_count    = tcnt_q;
  assign mon.running        = running_q;
  assign mon.done           = done_q;
  assign mon.halt_reason    = reason_q;
  assign mon.cycle_count    = cycle_q;
  assign mon.halt_pc        = halt_pc_q;
endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed plan cases plus randomized runs
// checked against a queue-based run model.
module tb_cpu_run_monitor;
  localparam int AW  = 32;
  localparam int IWD = 32;
  localparam int TD  = 16;
  localparam int CW  = 16;
  localparam int TMO = 100;
  localparam int LL  = 3;
  localparam int XW  = $clog2(TD);
  localparam logic [31:0] NOP = 32'h2000_0000;
  localparam logic [31:0] SYS = 32'h0000_000C;

  logic clk = 1'b0;
  logic rst_n;
  always #50 clk = ~clk;

  cpu_run_monitor_if #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IWD),
    .TRACE_DEPTH(TD), .CNT_WIDTH(CW)
  ) bus ();

  cpu_run_monitor #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IWD),
    .TRACE_DEPTH(TD), .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TMO), .LOOP_LIMIT(LL)
  ) dut (
    .clk(clk),
    .reset_n(rst_n),
    .mon(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 done
  int          m_st  = 0;
  int          m_cyc = 0;
  int          m_rsn = 0;
  int          m_run = 0;
  logic [31:0] m_hpc = '0;
  logic [31:0] m_prev = '0;
  logic [63:0] m_tr[$];
  logic [31:0] lo = '0;
  logic [31:0] hi = '1;

  task automatic m_clear();
    m_cyc = 0; m_rsn = 0; m_run = 0; m_hpc = '0;
    m_tr.delete();
  endtask

  task automatic m_step(bit r, bit s, logic [31:0] p, logic [31:0] in);
    if (!r) begin
      m_st = 0;
      m_clear();
    end else if (m_st != 1) begin
      if (s) begin
        m_st = 1;
        m_clear();
      end
    end else begin
      m_tr.push_back({p, in});
      if (m_tr.size() > TD) void'(m_tr.pop_front());
      m_run  = (m_cyc > 0 && p == m_prev) ? m_run + 1 : 1;
      m_prev = p;
      m_cyc++;
      if (in[31:26] == 6'h00 && in[5:0] == 6'h0C) m_rsn = 1;
`ifdef CPU_MON_PC_RANGE_EN
      else if (p < lo || p > hi) m_rsn = 4;
`endif
      else if (m_run >= LL) m_rsn = 2;
      else if (m_cyc == TMO) m_rsn = 3;
      if (m_rsn != 0) begin
        m_st  = 2;
        m_hpc = p;
      end
    end
  endtask

  task automatic cyc(bit r, bit s, logic [31:0] p, logic [31:0] in);
    rst_n           = r;
    bus.start       = s;
    bus.pc          = p;
    bus.instruction = in;
`ifdef CPU_MON_PC_RANGE_EN
    bus.pc_lo = lo;
    bus.pc_hi = hi;
`endif
    @(posedge clk);
    m_step(r, s, p, in);
    @(negedge clk);
    chk("running", bus.running, m_st == 1);
    chk("done", bus.done, m_st == 2);
    chk("reason", bus.halt_reason, m_rsn);
    chk("cycles", bus.cycle_count, m_cyc);
    chk("halt_pc", bus.halt_pc, m_hpc);
    chk("tcount", bus.trace_count, m_tr.size());
  endtask

  task automatic chk_trace();
    for (int i = 0; i < m_tr.size(); i++) begin
      bus.trace_rd_idx = XW'(i);
      #1;
      chk("trace", {bus.trace_rd_pc, bus.trace_rd_instr}, m_tr[i]);
    end
    bus.trace_rd_idx = '0;
  endtask

  logic [31:0] cur_pc;
  logic [31:0] rnd;
  bit          r_b, s_b, traced;

  initial begin
    bus.trace_rd_idx = '0;

    // Reset and start
    cyc(0, 0, 0, NOP);
    cyc(0, 0, 0, NOP);
    cyc(1, 0, 0, NOP);
    chk("rst_running", bus.running, 0);
    chk("rst_tcount", bus.trace_count, 0);
    cyc(1, 1, 0, NOP);
    chk("start_running", bus.running, 1);

    // Syscall halt
    cyc(1, 0, 32'h0, NOP);
    cyc(1, 0, 32'h4, NOP);
    cyc(1, 0, 32'h8, SYS);
    chk("sys_reason", bus.halt_reason, 1);
    chk("sys_pc", bus.halt_pc, 32'h8);
    chk("sys_cycles", bus.cycle_count, 3);
    chk("sys_tcount", bus.trace_count, 3);
    chk_trace();

    // Self-loop halt
    cyc(1, 1, 0, NOP);
    cyc(1, 0, 32'h0, 32'h1000FFFF);
    cyc(1, 0, 32'h4, 32'h1000FFFF);
    cyc(1, 0, 32'h4, 32'h1000FFFF);
    chk("loop_not_yet", bus.running, 1);
    cyc(1, 0, 32'h4, 32'h1000FFFF);
    chk("loop_reason", bus.halt_reason, 2);
    chk("loop_pc", bus.halt_pc, 32'h4);
    chk("loop_cycles", bus.cycle_count, 4);

    // Timeout with ring wrap
    cyc(1, 1, 0, NOP);
    for (int i = 0; i < TMO; i++) cyc(1, 0, 32'(i * 4), NOP);
    chk("tmo_reason", bus.halt_reason, 3);
    chk("tmo_cycles", bus.cycle_count, TMO);
    chk("tmo_tcount", bus.trace_count, TD);
    bus.trace_rd_idx = XW'(0);
    #1 chk("tmo_idx0", bus.trace_rd_pc, 32'h150);
    bus.trace_rd_idx = XW'(15);
    #1 chk("tmo_idx15", bus.trace_rd_pc, 32'h18C);
    chk_trace();

    // Syscall coinciding with timeout; restart from DONE
    cyc(1, 1, 0, NOP);
    for (int i = 0; i < TMO - 1; i++) cyc(1, 0, 32'(i * 4), NOP);
    cyc(1, 0, 32'h1000, SYS);
    chk("simul_reason", bus.halt_reason, 1);

    // start during RUN is ignored
    cyc(1, 1, 0, NOP);
    cyc(1, 0, 32'h10, NOP);
    cyc(1, 1, 32'h14, NOP);
    cyc(1, 0, 32'h18, NOP);
    chk("ign_cycles", bus.cycle_count, 3);

    // Reset mid-run
    cyc(1, 0, 32'h1C, NOP);
    cyc(0, 0, 32'h20, NOP);
    chk("midrst_cycles", bus.cycle_count, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_run", bus.running, 0);

`ifdef CPU_MON_PC_RANGE_EN
    lo = 32'h0;
    hi = 32'h0FFC;
    cyc(1, 1, 0, NOP);
    cyc(1, 0, 32'h0FF8, NOP);
    cyc(1, 0, 32'h0FFC, NOP);
    cyc(1, 0, 32'h1000, NOP);
    chk("range_reason", bus.halt_reason, 4);
    lo = 32'h0;
    hi = 32'h8000_0000;
`endif

    // Randomized runs
    cur_pc = '0;
    traced = 0;
    for (int n = 0; n < 4000; n++) begin
      r_b = ($urandom % 300) != 0;
      s_b = (m_st == 1) ? (($urandom % 25) == 0)
                        : (($urandom % 3) == 0);
      rnd = $urandom;
      case ($urandom % 20)
        0, 1, 2:    cur_pc = {rnd[31:2], 2'b00};
        3, 4, 5, 6: cur_pc = cur_pc;
        default:    cur_pc = cur_pc + 32'd4;
      endcase
      rnd = $urandom;
      if (($urandom % 40) == 0) rnd = {6'h00, rnd[25:6], 6'h0C};
      cyc(r_b, s_b, cur_pc, rnd);
      if (m_st == 2 && !traced) begin
        chk_trace();
        traced = 1;
      end
      if (m_st != 2) traced = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
